// File: rtl/lcd_read_cycle.sv
// HD44780 bus read sequencer: drives RS/RW/E for one read (or a busy-flag poll loop)
// and captures the data bus at the end of the E-high window.
module lcd_read_cycle #(
   parameter int SETUP_CYC  = 1,
   parameter int E_HIGH_CYC = 2,
   parameter int HOLD_CYC   = 1,
   parameter int MAX_POLLS  = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rd_enable,
   input  logic       reg_sel,
   input  logic       poll,
   input  logic [7:0] db_in,
   output logic       rs_out,
   output logic       rw_out,
   output logic       e_out,
   output logic       bus_rd,
   output logic [7:0] rd_data,
   output logic       busy_flag,
   output logic [6:0] addr_out,
   output logic       rd_finish,
   output logic       timeout
);

   localparam int MAX_CYC = (SETUP_CYC > E_HIGH_CYC)
                            ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                            : ((E_HIGH_CYC > HOLD_CYC) ? E_HIGH_CYC : HOLD_CYC);
   localparam int PW = $clog2(MAX_CYC) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_E_HIGH,
      S_HOLD,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   last_cnt;
   logic            phase_end;
   logic            rs_q, rs_d;
   logic            poll_q, poll_d;
   logic [7:0]      poll_cnt_q, poll_cnt_d;
   logic [7:0]      rd_data_q, rd_data_d;
   logic            busy_q, busy_d;
   logic [6:0]      addr_q, addr_d;
   logic            timeout_q, timeout_d;

   // NOTE: every variable written here gets a default first, so no path leaves one unassigned and infers a latch.
   always_comb begin
      last_cnt = '0;
      case (state_q)
         S_SETUP:  last_cnt = PW'(SETUP_CYC - 1);
         S_E_HIGH: last_cnt = PW'(E_HIGH_CYC - 1);
         S_HOLD:   last_cnt = PW'(HOLD_CYC - 1);
         default:  last_cnt = '0;
      endcase
      phase_end = (cnt_q == last_cnt);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rs_d       = rs_q;
      poll_d     = poll_q;
      poll_cnt_d = poll_cnt_q;
      rd_data_d  = rd_data_q;
      busy_d     = busy_q;
      addr_d     = addr_q;
      timeout_d  = timeout_q;
      rs_out     = 1'b0;
      rw_out     = 1'b0;
      e_out      = 1'b0;
      bus_rd     = 1'b0;
      rd_finish  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rd_enable) begin
               rs_d       = reg_sel;
               poll_d     = poll & ~reg_sel;
               poll_cnt_d = '0;
               timeout_d  = 1'b0;
               cnt_d      = '0;
               state_d    = S_SETUP;
            end
         end
         S_SETUP: begin
            rs_out = rs_q;
            rw_out = 1'b1;
            bus_rd = 1'b1;
            if (phase_end) begin
               cnt_d   = '0;
               state_d = S_E_HIGH;
            end else begin
               cnt_d = cnt_q + PW'(1);
            end
         end
         S_E_HIGH: begin
            rs_out = rs_q;
            rw_out = 1'b1;
            bus_rd = 1'b1;
            e_out  = 1'b1;
            if (phase_end) begin
               // Capture on the last E-high edge, when the LCD output has had the full window to settle.
               rd_data_d = db_in;
               if (!rs_q) begin
                  busy_d = db_in[7];
                  addr_d = db_in[6:0];
               end
               cnt_d   = '0;
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + PW'(1);
            end
         end
         S_HOLD: begin
            rs_out = rs_q;
            rw_out = 1'b1;
            bus_rd = 1'b1;
            if (phase_end) begin
               cnt_d   = '0;
               state_d = S_DONE;
               if (poll_q && busy_q) begin
                  if (({1'b0, poll_cnt_q} + 9'd1) < 9'(MAX_POLLS)) begin
                     poll_cnt_d = poll_cnt_q + 8'd1;
                     state_d    = S_SETUP;
                  end else begin
                     timeout_d = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + PW'(1);
            end
         end
         S_DONE: begin
            rd_finish = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; the async reset also clears the bus
   // controls at once because they decode combinationally from state_q.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rs_q       <= 1'b0;
         poll_q     <= 1'b0;
         poll_cnt_q <= '0;
         rd_data_q  <= '0;
         busy_q     <= 1'b0;
         addr_q     <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rs_q       <= rs_d;
         poll_q     <= poll_d;
         poll_cnt_q <= poll_cnt_d;
         rd_data_q  <= rd_data_d;
         busy_q     <= busy_d;
         addr_q     <= addr_d;
         timeout_q  <= timeout_d;
      end
   end

   assign rd_data   = rd_data_q;
   assign busy_flag = busy_q;
   assign addr_out  = addr_q;
   assign timeout   = timeout_q;

endmodule
